// File: rtl/ncl_entrada_somador_if.sv
// Handshake and dual-rail bus between the clocked producer, the injector and the NCL adder stage.
interface ncl_entrada_somador_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_cin;
  logic       ack_in;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] cin;
  logic       busy;
  logic       err;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, ack_in,
    output in_ready, a, b, cin, busy, err
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, ack_in,
    input  in_ready, a, b, cin, busy, err
  );
endinterface

// File: rtl/ncl_entrada_somador.sv
// Clocked-to-NCL injector: encodes accepted single-rail operands as DATA/NULL wavefronts paced by ack_in.
// Optional acknowledge timeout flag is built when ENTRADA_TIMEOUT_EN is defined.
module ncl_entrada_somador #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  ncl_entrada_somador_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NULLW = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     ack_s;
  logic [7:0]               a_q, a_d;
  logic [7:0]               b_q, b_d;
  logic [1:0]               cin_q, cin_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  function automatic logic [1:0] enc1(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      r[2*i +: 2] = enc1(v[i]);
    end
    return r;
  endfunction

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Acknowledge synchronizer into the clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  // Wavefront sequencing; rails are only ever loaded with a full word or all-NULL
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          state_d = DATA;
          a_d     = enc4(bus.in_a);
          b_d     = enc4(bus.in_b);
          cin_d   = enc1(bus.in_cin);
        end else begin
          a_d   = 8'h00;
          b_d   = 8'h00;
          cin_d = 2'b00;
        end
      end
      DATA: begin
        if (ack_s) begin
          state_d = NULLW;
          a_d     = 8'h00;
          b_d     = 8'h00;
          cin_d   = 2'b00;
        end else begin
          state_d = DATA;
        end
      end
      NULLW: begin
        a_d   = 8'h00;
        b_d   = 8'h00;
        cin_d = 2'b00;
        if (!ack_s) begin
          state_d = IDLE;
        end else begin
          state_d = NULLW;
        end
      end
      default: begin
        state_d = IDLE;
        a_d     = 8'h00;
        b_d     = 8'h00;
        cin_d   = 2'b00;
      end
    endcase
    // ready looks ahead to the synchronizer value that will be ack_s next cycle
    ready_d = (state_d == IDLE) && !sync_q[SYNC_STAGES-2];
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset drives every rail NULL at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cin_q   <= 2'b00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef ENTRADA_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait counter restarts on each state change and saturates at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && (cnt_q != TO_CNT)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    err_d = err_q | (cnt_q == TO_CNT);
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign err_d = 1'b0;

  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.cin      = cin_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ncl_entrada_somador.sv
// Directed self-checking bench for ncl_entrada_somador with hand-computed dual-rail words.
module tb_ncl_entrada_somador;

  localparam int SYNC = 2;
  localparam int TO   = 16;
`ifdef ENTRADA_TIMEOUT_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic rail11_seen;

  ncl_entrada_somador_if bus ();

  ncl_entrada_somador #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watch for the forbidden 2'b11 rail code throughout the run
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.a[2*i +: 2] == 2'b11 || bus.b[2*i +: 2] == 2'b11) rail11_seen = 1'b1;
    end
    if (bus.cin == 2'b11) rail11_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rails(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] ec);
    check({tag, ".a"}, bus.a, ea);
    check({tag, ".b"}, bus.b, eb);
    check({tag, ".cin"}, {6'd0, bus.cin}, {6'd0, ec});
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rail11_seen   = 1'b0;
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'($urandom);
    bus.in_b      = 4'($urandom);
    bus.in_cin    = 1'($urandom);
    bus.ack_in    = 1'b0;

    // reset state with random inputs
    step(2);
    rails("rst", 8'h00, 8'h00, 2'b00);
    check("rst.ready", {7'd0, bus.in_ready}, 8'd0);
    check("rst.busy", {7'd0, bus.busy}, 8'd0);
    check("rst.err", {7'd0, bus.err}, 8'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step(1);
    check("rel.ready", {7'd0, bus.in_ready}, 8'd1);

    // encode A/5/1 and run one full handshake
    bus.in_a = 4'hA; bus.in_b = 4'h5; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    step(1);
    rails("enc", 8'h99, 8'h66, 2'b10);
    check("enc.busy", {7'd0, bus.busy}, 8'd1);
    check("enc.ready", {7'd0, bus.in_ready}, 8'd0);
    bus.in_valid = 1'b0; bus.in_a = 4'h3; bus.in_b = 4'hC; bus.in_cin = 1'b0;
    bus.ack_in = 1'b1;
    step(SYNC);
    rails("enc.hold", 8'h99, 8'h66, 2'b10);
    step(1);
    rails("enc.null", 8'h00, 8'h00, 2'b00);
    bus.ack_in = 1'b0;
    step(SYNC);
    check("enc.ready_early", {7'd0, bus.in_ready}, 8'd0);
    step(1);
    check("enc.ready_back", {7'd0, bus.in_ready}, 8'd1);
    check("enc.busy_done", {7'd0, bus.busy}, 8'd0);

    // back-to-back with in_valid held
    bus.in_a = 4'h0; bus.in_b = 4'hF; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    step(1);
    rails("b2b.w1", 8'h55, 8'hAA, 2'b01);
    bus.in_a = 4'hF; bus.in_b = 4'h0; bus.in_cin = 1'b1;
    bus.ack_in = 1'b1;
    step(SYNC + 1);
    rails("b2b.null", 8'h00, 8'h00, 2'b00);
    bus.ack_in = 1'b0;
    step(SYNC + 1);
    rails("b2b.idle", 8'h00, 8'h00, 2'b00);
    step(1);
    rails("b2b.w2", 8'hAA, 8'h55, 2'b10);
    bus.in_valid = 1'b0;
    bus.ack_in = 1'b1;
    step(SYNC + 1);
    bus.ack_in = 1'b0;
    step(SYNC + 1);
    check("b2b.busy_done", {7'd0, bus.busy}, 8'd0);

    // stale acknowledge held across reset release
    reset = 1'b0;
    bus.ack_in = 1'b1;
    step(2);
    reset = 1'b1;
    step(SYNC + 1);
    bus.in_a = 4'h3; bus.in_b = 4'hC; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    check("stale.ready", {7'd0, bus.in_ready}, 8'd0);
    step(4);
    check("stale.ready_hold", {7'd0, bus.in_ready}, 8'd0);
    check("stale.busy", {7'd0, bus.busy}, 8'd0);
    rails("stale.null", 8'h00, 8'h00, 2'b00);
    bus.ack_in = 1'b0;
    step(SYNC);
    check("stale.ready_back", {7'd0, bus.in_ready}, 8'd1);
    step(1);
    rails("stale.acc", 8'h5A, 8'hA5, 2'b01);
    bus.in_valid = 1'b0;
    bus.ack_in = 1'b1;
    step(SYNC + 1);
    bus.ack_in = 1'b0;
    step(SYNC + 1);

    // reset asserted while DATA is on the rails
    bus.in_a = 4'hA; bus.in_b = 4'h5; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    step(1);
    rails("mid.data", 8'h99, 8'h66, 2'b10);
    reset = 1'b0;
    #2;
    rails("mid.async", 8'h00, 8'h00, 2'b00);
    check("mid.busy", {7'd0, bus.busy}, 8'd0);
    step(1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step(3);
    rails("mid.after", 8'h00, 8'h00, 2'b00);
    check("mid.ready", {7'd0, bus.in_ready}, 8'd1);
    check("mid.idle", {7'd0, bus.busy}, 8'd0);

    // acknowledge never arrives
    bus.in_a = 4'h3; bus.in_b = 4'hC; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    check("to.err_early", {7'd0, bus.err}, 8'd0);
    step(TO + 5);
    check("to.err", {7'd0, bus.err}, {7'd0, ERR_EXP});
    rails("to.wait", 8'h5A, 8'hA5, 2'b01);
    bus.ack_in = 1'b1;
    step(SYNC + 1);
    rails("to.null", 8'h00, 8'h00, 2'b00);
    bus.ack_in = 1'b0;
    step(SYNC + 1);
    check("to.busy_done", {7'd0, bus.busy}, 8'd0);
    check("to.err_sticky", {7'd0, bus.err}, {7'd0, ERR_EXP});
    reset = 1'b0;
    #2;
    check("to.err_clr", {7'd0, bus.err}, 8'd0);
    reset = 1'b1;
    step(2);

    check("rail11", {7'd0, rail11_seen}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
